dot_product_stream: RTL and testbench

//  Streaming dot product of two N-element vectors delivered serially on one input bus.
//  - Element order per vector pair: A[0..N-1], then B[0..N-1].
//  - A is buffered; each accepted B element is multiply-accumulated on the fly.
//  - Result is presented on a valid/ready output; an abort input discards any partial work.
//  - Parametrised successor of the fixed 8-bit, 3-element dot-product unit.

---
 rtl/dot_product_stream.sv | 144 ++++++++++++++
 tb/tb_dot_product_stream.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_stream.sv
// -----------------------------------------------------------------------------
// dot_product_stream
//   Streaming dot product of two N-element vectors delivered serially on one
//   input bus. Per vector pair the elements arrive as A[0..N-1] then
//   B[0..N-1]. A is buffered; every accepted B element is multiplied with the
//   matching A element and accumulated on the fly. The finished sum is offered
//   on a valid/ready output port. An abort input throws away partial work.
//
//   Handshake: a transfer happens on a rising clk edge where valid && ready
//   are both high (din_valid/din_ready on the input side, dout_valid/
//   dout_ready on the output side). din_ready depends only on the state, never
//   on din_valid, and dout/dout_valid stay stable until the result transfers.
//
// Parameters
//   DW      element width in bits (>= 2)
//   N       vector length (>= 1)
//   SIGNED  0: unsigned operands, 1: two's complement operands
//   OW      result width, 2*DW + clog2(N) (derived, wide enough to never wrap)
//
// Ports
//   clk         in   clock, all logic on the rising edge
//   reset       in   synchronous active-high reset, dominates everything
//   din         in   input element (DW bits)
//   din_valid   in   din carries an element this cycle
//   din_ready   out  block can accept din this cycle
//   abort       in   discard the partial vector pair or the pending result
//   dout        out  dot product (OW bits), sign-extended when SIGNED=1
//   dout_valid  out  dout holds an unconsumed result
//   dout_ready  in   sink accepts dout this cycle
//   phase       out  state: 0 LOAD_A, 1 MAC_B, 2 OUT
// -----------------------------------------------------------------------------
module dot_product_stream #(
    parameter int  DW     = 8,
    parameter int  N      = 3,
    parameter int  SIGNED = 0,
    localparam int OW     = 2 * DW + $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic          abort,
    output logic [OW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [1:0]    phase
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_LOAD_A = 2'd0;
    localparam logic [1:0] S_MAC_B  = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [1:0]      state;
    logic [IW-1:0]   idx;
    logic [OW-1:0]   acc;
    logic [DW-1:0]   a_buf [N];

    logic [DW-1:0]   a_sel;
    logic [2*DW-1:0] prod_u;
    logic [2*DW-1:0] prod_s;
    logic [OW-1:0]   prod_ext;
    logic            last_elem;

    assign din_ready = (state != S_OUT);
    assign phase     = state;
    assign last_elem = (idx == IDX_LAST);
    assign a_sel     = a_buf[idx];

    // Both products are formed at full 2*DW width from explicitly extended
    // operands; the low 2*DW bits of the signed product are exact.
    always_comb begin
        prod_u   = {{DW{1'b0}}, a_sel} * {{DW{1'b0}}, din};
        prod_s   = {{DW{a_sel[DW-1]}}, a_sel} * {{DW{din[DW-1]}}, din};
        prod_ext = '0;
        if (SIGNED != 0) begin
            prod_ext = OW'($signed(prod_s));
        end else begin
            prod_ext = OW'(prod_u);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD_A;
            idx        <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_buf[i] <= '0;
            end
        end else if (abort) begin
            // A buffer and dout are left alone: a new pair overwrites A and
            // dout is only meaningful while dout_valid is high.
            state      <= S_LOAD_A;
            idx        <= '0;
            acc        <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                S_LOAD_A: begin
                    if (din_valid) begin
                        a_buf[idx] <= din;
                        if (last_elem) begin
                            idx   <= '0;
                            acc   <= '0;
                            state <= S_MAC_B;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_MAC_B: begin
                    if (din_valid) begin
                        if (last_elem) begin
                            dout       <= acc + prod_ext;
                            dout_valid <= 1'b1;
                            idx        <= '0;
                            state      <= S_OUT;
                        end else begin
                            acc <= acc + prod_ext;
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        state      <= S_LOAD_A;
                    end
                end
                default: begin
                    state <= S_LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_stream.sv
// -----------------------------------------------------------------------------
// tb_dot_product_stream
//   Drives an unsigned and a signed instance (DW=8, N=3) with the same element
//   stream. Expected results come from a constant table or a small arithmetic
//   model, are queued when the last B element is accepted, and are compared by
//   a negedge monitor when each DUT hands a result over.
// -----------------------------------------------------------------------------
module tb_dot_product_stream;

    localparam int DW = 8;
    localparam int N  = 3;
    localparam int OW = 18;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          abort;
    logic          dout_ready;

    logic          din_ready_u, din_ready_s;
    logic [OW-1:0] dout_u, dout_s;
    logic          dout_valid_u, dout_valid_s;
    logic [1:0]    phase_u, phase_s;

    dot_product_stream #(.DW(DW), .N(N), .SIGNED(0)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_u),
        .abort      (abort),
        .dout       (dout_u),
        .dout_valid (dout_valid_u),
        .dout_ready (dout_ready),
        .phase      (phase_u)
    );

    dot_product_stream #(.DW(DW), .N(N), .SIGNED(1)) u_dut_s (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready_s),
        .abort      (abort),
        .dout       (dout_s),
        .dout_valid (dout_valid_s),
        .dout_ready (dout_ready),
        .phase      (phase_s)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q_u[$];
    logic [OW-1:0] exp_q_s[$];
    logic [OW-1:0] front_u, front_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: a result transfers at the next rising edge when valid,
    // ready and no abort/reset are present; abort or reset drops it instead.
    always @(negedge clk) begin
        if (reset) begin
            exp_q_u.delete();
            exp_q_s.delete();
        end else if (abort) begin
            if (dout_valid_u && exp_q_u.size() > 0) front_u = exp_q_u.pop_front();
            if (dout_valid_s && exp_q_s.size() > 0) front_s = exp_q_s.pop_front();
        end else begin
            if (dout_valid_u && dout_ready) begin
                if (exp_q_u.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_u got %0d required none", dout_u);
                end else begin
                    front_u = exp_q_u.pop_front();
                    check("dout_u", 32'(dout_u), 32'(front_u));
                end
            end
            if (dout_valid_s && dout_ready) begin
                if (exp_q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_s got %0d required none", dout_s);
                end else begin
                    front_s = exp_q_s.pop_front();
                    check("dout_s", 32'(dout_s), 32'(front_s));
                end
            end
        end
    end

    // ---------------- model ----------------
    function automatic logic [OW-1:0] model_u(input logic [2:0][7:0] a, input logic [2:0][7:0] b);
        int sum = 0;
        for (int i = 0; i < N; i++) sum += int'(a[i]) * int'(b[i]);
        return OW'(sum);
    endfunction

    function automatic logic [OW-1:0] model_s(input logic [2:0][7:0] a, input logic [2:0][7:0] b);
        int sum = 0;
        int sa, sb;
        for (int i = 0; i < N; i++) begin
            sa = $signed(a[i]);
            sb = $signed(b[i]);
            sum += sa * sb;
        end
        return OW'(sum);
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic send_elem(input logic [7:0] v, input int gap_max);
        int n;
        repeat ($urandom_range(0, gap_max)) begin
            din_valid = 1'b0;
            @(posedge clk); #1;
        end
        din       = v;
        din_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (din_ready_u) break;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL din_ready_timeout got 0 required 1");
                break;
            end
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [2:0][7:0] a, input logic [2:0][7:0] b,
                             input logic [OW-1:0] eu, input logic [OW-1:0] es,
                             input int gap_max);
        for (int i = 0; i < N; i++) send_elem(a[i], gap_max);
        for (int i = 0; i < N; i++) send_elem(b[i], gap_max);
        exp_q_u.push_back(eu);
        exp_q_s.push_back(es);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- vector table ----------------
    // Packed vectors list element 2 first: {e2, e1, e0}.
    typedef struct {
        logic [2:0][7:0] a;
        logic [2:0][7:0] b;
        logic [OW-1:0]   exp_u;
        logic [OW-1:0]   exp_s;
    } vec_rec_t;

    vec_rec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0][7:0] ra, rb;

        tbl[0] = '{a: {8'd3, 8'd2, 8'd1},       b: {8'd6, 8'd5, 8'd4},
                   exp_u: 18'd32,     exp_s: 18'd32};
        tbl[1] = '{a: {8'hFF, 8'hFF, 8'hFF},    b: {8'hFF, 8'hFF, 8'hFF},
                   exp_u: 18'd195075, exp_s: 18'd3};
        tbl[2] = '{a: {8'hFD, 8'h02, 8'hFF},    b: {8'd6, 8'd5, 8'd4},
                   exp_u: 18'd2548,   exp_s: 18'h3FFF4};
        tbl[3] = '{a: {8'h80, 8'h80, 8'h80},    b: {8'h80, 8'h80, 8'h80},
                   exp_u: 18'd49152,  exp_s: 18'd49152};
        tbl[4] = '{a: {8'h01, 8'h80, 8'h02},    b: {8'hFF, 8'h01, 8'h03},
                   exp_u: 18'd389,    exp_s: 18'h3FF85};

        reset      = 1'b1;
        din        = '0;
        din_valid  = 1'b0;
        abort      = 1'b0;
        dout_ready = 1'b1;
        idle(3);
        reset = 1'b0;

        // Reset values
        @(negedge clk);
        check("reset_phase", 32'(phase_u), 32'd0);
        check("reset_din_ready", 32'(din_ready_u), 32'd1);
        check("reset_dout_valid", 32'(dout_valid_u), 32'd0);
        check("reset_dout", 32'(dout_u), 32'd0);
        @(posedge clk); #1;

        // Table, back-to-back; result must be valid the cycle after last B
        for (int i = 0; i < 5; i++) begin
            send_pair(tbl[i].a, tbl[i].b, tbl[i].exp_u, tbl[i].exp_s, 0);
            check("latency_valid", 32'(dout_valid_u), 32'd1);
            check("latency_phase", 32'(phase_u), 32'd2);
        end

        // Table again with random valid gaps
        for (int i = 0; i < 5; i++) begin
            send_pair(tbl[i].a, tbl[i].b, tbl[i].exp_u, tbl[i].exp_s, 3);
        end

        // Random operands against the model
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < N; i++) begin
                ra[i] = 8'($urandom_range(0, 255));
                rb[i] = 8'($urandom_range(0, 255));
            end
            send_pair(ra, rb, model_u(ra, rb), model_s(ra, rb), 2);
        end
        idle(2);

        // Backpressure: result held, input blocked while din_valid stays high
        dout_ready = 1'b0;
        send_pair(tbl[0].a, tbl[0].b, tbl[0].exp_u, tbl[0].exp_s, 0);
        din       = 8'h55;
        din_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_dout_valid", 32'(dout_valid_u), 32'd1);
            check("bp_dout", 32'(dout_u), 32'd32);
            check("bp_din_ready", 32'(din_ready_u), 32'd0);
            @(posedge clk); #1;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        idle(1);
        send_pair(tbl[2].a, tbl[2].b, tbl[2].exp_u, tbl[2].exp_s, 0);
        idle(2);

        // Abort together with the 5th element, then a fresh pair
        for (int i = 0; i < 4; i++) send_elem(8'd7, 0);
        din       = 8'd9;
        din_valid = 1'b1;
        abort     = 1'b1;
        @(posedge clk); #1;
        abort     = 1'b0;
        din_valid = 1'b0;
        check("abort_phase", 32'(phase_u), 32'd0);
        send_pair({8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2}, 18'd6, 18'd6, 0);
        idle(2);

        // Abort in OUT with dout_ready high: result discarded
        dout_ready = 1'b0;
        send_pair(tbl[1].a, tbl[1].b, tbl[1].exp_u, tbl[1].exp_s, 0);
        abort      = 1'b1;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_out_valid", 32'(dout_valid_u), 32'd0);
        check("abort_out_phase", 32'(phase_u), 32'd0);
        send_pair(tbl[4].a, tbl[4].b, tbl[4].exp_u, tbl[4].exp_s, 1);
        idle(2);

        // Reset while in MAC_B
        for (int i = 0; i < 4; i++) send_elem(8'd11, 0);
        check("pre_reset_phase", 32'(phase_u), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_phase", 32'(phase_u), 32'd0);
        check("midreset_dout_valid", 32'(dout_valid_u), 32'd0);
        check("midreset_dout", 32'(dout_u), 32'd0);
        send_pair(tbl[3].a, tbl[3].b, tbl[3].exp_u, tbl[3].exp_s, 0);
        idle(4);

        check("queue_u_empty", 32'(exp_q_u.size()), 32'd0);
        check("queue_s_empty", 32'(exp_q_s.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
